// File: rtl/varredor_tabela_if.sv
// Bus between the truth-table sweeper and the combinational block it characterises.
// Signal names are given from the sweeper's point of view.
interface varredor_tabela_if;
   logic        i_start;
   logic        i_s1;
   logic        o_a;
   logic        o_b;
   logic        o_c;
   logic        o_d;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_tabela;
   logic [4:0]  o_uns;

   modport slave (
      input  i_start, i_s1,
      output o_a, o_b, o_c, o_d, o_busy, o_done, o_tabela, o_uns
   );

   modport master (
      output i_start, i_s1,
      input  o_a, o_b, o_c, o_d, o_busy, o_done, o_tabela, o_uns
   );
endinterface

// File: rtl/varredor_tabela.sv
// Truth-table sweeper: walks {a,b,c,d} through 0..15, samples s1 and builds a 16-bit table.
// Optional popcount of the table on o_uns is compiled in with VARREDOR_UNS_EN.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for i_start
// ST_DRIVE | holding vector r_idx for DWELL cycles, sample s1 on the last one
// ST_DONE  | table complete; o_done on first cycle only, waiting for i_start
module varredor_tabela #(
   parameter int DWELL = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   varredor_tabela_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [7:0] LP_CNT_LAST = 8'(DWELL - 1);

   logic [1:0]  r_state;
   logic [3:0]  r_idx;
   logic [7:0]  r_cnt;
   logic [15:0] r_tabela;
   logic        r_busy;
   logic        r_done;

   logic w_accept;
   logic w_sample;

   assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.i_start;
   assign w_sample = (r_state == ST_DRIVE) && (r_cnt == LP_CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_idx    <= 4'd0;
         r_cnt    <= 8'd0;
         r_tabela <= 16'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  r_state  <= ST_DRIVE;
                  r_idx    <= 4'd0;
                  r_cnt    <= 8'd0;
                  r_tabela <= 16'd0;
                  r_busy   <= 1'b1;
               end
            end
            ST_DRIVE: begin
               if (w_sample) begin
                  r_cnt           <= 8'd0;
                  r_tabela[r_idx] <= bus.i_s1;
                  // Termination is decided on index 15 itself, so the vector bus drops to 0000 in DONE.
                  if (r_idx == 4'd15) begin
                     r_state <= ST_DONE;
                     r_idx   <= 4'd0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_idx   <= 4'd0;
               r_cnt   <= 8'd0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef VARREDOR_UNS_EN
   logic [4:0] r_uns;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_uns <= 5'd0;
      end else if (w_accept) begin
         r_uns <= 5'd0;
      end else if (w_sample && bus.i_s1) begin
         r_uns <= r_uns + 5'd1;
      end
   end

   assign bus.o_uns = r_uns;
`else
   assign bus.o_uns = 5'd0;
`endif

   assign bus.o_a      = r_idx[3];
   assign bus.o_b      = r_idx[2];
   assign bus.o_c      = r_idx[1];
   assign bus.o_d      = r_idx[0];
   assign bus.o_busy   = r_busy;
   assign bus.o_done   = r_done;
   assign bus.o_tabela = r_tabela;

endmodule

// File: tb/tb_varredor_tabela.sv
// Directed bench for varredor_tabela: three instances (DWELL 4, 2, 3) with a&b or constant s1 models.
module tb_varredor_tabela;

`ifdef VARREDOR_UNS_EN
   localparam bit UNS_ON = 1'b1;
`else
   localparam bit UNS_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_v;
   logic [2:0] start_v;
   logic [1:0] mode_v [3];

   logic        busy_w [3];
   logic        done_w [3];
   logic [15:0] tab_w  [3];
   logic [4:0]  uns_w  [3];
   logic [3:0]  vec_w  [3];

   int n_tests = 0;
   int n_fail  = 0;

   varredor_tabela_if bus0 ();
   varredor_tabela_if bus1 ();
   varredor_tabela_if bus2 ();

   varredor_tabela #(.DWELL(4)) u_dut0 (.i_clk(clk), .i_rst(rst_v[0]), .bus(bus0.slave));
   varredor_tabela #(.DWELL(2)) u_dut1 (.i_clk(clk), .i_rst(rst_v[1]), .bus(bus1.slave));
   varredor_tabela #(.DWELL(3)) u_dut2 (.i_clk(clk), .i_rst(rst_v[2]), .bus(bus2.slave));

   // mode 0: s1 = a & b, mode 1: s1 tied 1, mode 2: s1 tied 0
   assign bus0.i_start = start_v[0];
   assign bus1.i_start = start_v[1];
   assign bus2.i_start = start_v[2];
   assign bus0.i_s1 = (mode_v[0] == 2'd0) ? (bus0.o_a & bus0.o_b) : (mode_v[0] == 2'd1);
   assign bus1.i_s1 = (mode_v[1] == 2'd0) ? (bus1.o_a & bus1.o_b) : (mode_v[1] == 2'd1);
   assign bus2.i_s1 = (mode_v[2] == 2'd0) ? (bus2.o_a & bus2.o_b) : (mode_v[2] == 2'd1);

   assign busy_w[0] = bus0.o_busy;
   assign busy_w[1] = bus1.o_busy;
   assign busy_w[2] = bus2.o_busy;
   assign done_w[0] = bus0.o_done;
   assign done_w[1] = bus1.o_done;
   assign done_w[2] = bus2.o_done;
   assign tab_w[0]  = bus0.o_tabela;
   assign tab_w[1]  = bus1.o_tabela;
   assign tab_w[2]  = bus2.o_tabela;
   assign uns_w[0]  = bus0.o_uns;
   assign uns_w[1]  = bus1.o_uns;
   assign uns_w[2]  = bus2.o_uns;
   assign vec_w[0]  = {bus0.o_a, bus0.o_b, bus0.o_c, bus0.o_d};
   assign vec_w[1]  = {bus1.o_a, bus1.o_b, bus1.o_c, bus1.o_d};
   assign vec_w[2]  = {bus2.o_a, bus2.o_b, bus2.o_c, bus2.o_d};

   function automatic logic [4:0] exp_uns(input int ones);
      return UNS_ON ? 5'(ones) : 5'd0;
   endfunction

   // Pulses start for one edge, then follows the sweep; lat is the cycle index (1 = first after
   // the start edge) in which done is seen. restart_at > 0 raises start again in that cycle.
   task automatic do_sweep(input int k, input int dw, input int restart_at,
                           output int lat, output logic [15:0] tab, output logic [4:0] un,
                           output int vec_err, output logic busy1);
      int n;
      logic [3:0] ev;
      @(negedge clk);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      n       = 1;
      vec_err = 0;
      busy1   = busy_w[k];
      while (done_w[k] !== 1'b1 && n < 2000) begin
         ev = 4'((n - 1) / dw);
         if (vec_w[k] !== ev || busy_w[k] !== 1'b1) vec_err++;
         start_v[k] = (n == restart_at);
         @(negedge clk);
         n++;
      end
      start_v[k] = 1'b0;
      lat = n;
      tab = tab_w[k];
      un  = uns_w[k];
      if (vec_w[k] !== 4'd0 || busy_w[k] !== 1'b0) vec_err++;
   endtask

   task automatic test_reset();
      rst_v   = 3'b111;
      start_v = 3'b000;
      for (int k = 0; k < 3; k++) mode_v[k] = 2'd0;
      repeat (2) @(negedge clk);
      rst_v = 3'b000;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if ({busy_w[k], done_w[k], vec_w[k], tab_w[k], uns_w[k]} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs inst%0d: got busy=%b done=%b vec=%h tab=%h uns=%0d, need all 0",
                     k, busy_w[k], done_w[k], vec_w[k], tab_w[k], uns_w[k]);
         end
      end
   endtask

   task automatic test_and_sweep();
      int lat, verr;
      logic [15:0] tab;
      logic [4:0] un;
      logic b1;
      mode_v[0] = 2'd0;
      do_sweep(0, 4, 0, lat, tab, un, verr, b1);
      n_tests++;
      if (b1 !== 1'b1) begin n_fail++; $display("FAIL and_busy_rise: got %b need 1", b1); end
      n_tests++;
      if (lat !== 65) begin n_fail++; $display("FAIL and_done_latency: got %0d need 65", lat); end
      n_tests++;
      if (tab !== 16'hF000) begin n_fail++; $display("FAIL and_tabela: got %h need f000", tab); end
      n_tests++;
      if (un !== exp_uns(4)) begin n_fail++; $display("FAIL and_uns: got %0d need %0d", un, exp_uns(4)); end
      @(negedge clk);
      n_tests++;
      if (done_w[0] !== 1'b0) begin n_fail++; $display("FAIL and_done_one_cycle: got %b need 0", done_w[0]); end
   endtask

   task automatic test_tied();
      int lat, verr;
      logic [15:0] tab;
      logic [4:0] un;
      logic b1;
      mode_v[1] = 2'd1;
      do_sweep(1, 2, 0, lat, tab, un, verr, b1);
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL tied1_latency: got %0d need 33", lat); end
      n_tests++;
      if (tab !== 16'hFFFF) begin n_fail++; $display("FAIL tied1_tabela: got %h need ffff", tab); end
      n_tests++;
      if (un !== exp_uns(16)) begin n_fail++; $display("FAIL tied1_uns: got %0d need %0d", un, exp_uns(16)); end
      mode_v[1] = 2'd2;
      do_sweep(1, 2, 0, lat, tab, un, verr, b1);
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL tied0_latency: got %0d need 33", lat); end
      n_tests++;
      if (tab !== 16'h0000 || un !== 5'd0) begin
         n_fail++; $display("FAIL tied0_table: got tab=%h uns=%0d need 0000/0", tab, un);
      end
   endtask

   task automatic test_vectors();
      int lat, verr;
      logic [15:0] tab;
      logic [4:0] un;
      logic b1;
      mode_v[2] = 2'd0;
      do_sweep(2, 3, 0, lat, tab, un, verr, b1);
      n_tests++;
      if (verr !== 0) begin n_fail++; $display("FAIL vec_sequence: got %0d bad cycles need 0", verr); end
      n_tests++;
      if (lat !== 49 || tab !== 16'hF000) begin
         n_fail++; $display("FAIL vec_sweep: got lat=%0d tab=%h need 49/f000", lat, tab);
      end
   endtask

   task automatic test_start_ignored();
      int lat, verr;
      logic [15:0] tab;
      logic [4:0] un;
      logic b1;
      do_sweep(0, 4, 7 * 4 + 2, lat, tab, un, verr, b1);
      n_tests++;
      if (lat !== 65 || verr !== 0) begin
         n_fail++; $display("FAIL midstart_timing: got lat=%0d vec_err=%0d need 65/0", lat, verr);
      end
      n_tests++;
      if (tab !== 16'hF000 || un !== exp_uns(4)) begin
         n_fail++; $display("FAIL midstart_table: got tab=%h uns=%0d need f000/%0d", tab, un, exp_uns(4));
      end
   endtask

   task automatic test_reset_mid();
      int lat, verr, n, seen;
      logic [15:0] tab;
      logic [4:0] un;
      logic b1;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      n = 1;
      while (n < 9 * 4 + 2) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (vec_w[0] !== 4'd9) begin n_fail++; $display("FAIL rstmid_at_vec9: got %h need 9", vec_w[0]); end
      // start held with reset in the same edge: reset must win
      rst_v[0]   = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      rst_v[0]   = 1'b0;
      start_v[0] = 1'b0;
      n_tests++;
      if ({busy_w[0], done_w[0], vec_w[0], tab_w[0], uns_w[0]} !== 27'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got busy=%b done=%b vec=%h tab=%h uns=%0d need all 0",
                  busy_w[0], done_w[0], vec_w[0], tab_w[0], uns_w[0]);
      end
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) seen++;
      end
      n_tests++;
      if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d active cycles need 0", seen); end
      do_sweep(0, 4, 0, lat, tab, un, verr, b1);
      n_tests++;
      if (lat !== 65 || tab !== 16'hF000 || verr !== 0) begin
         n_fail++; $display("FAIL rstmid_clean_sweep: got lat=%0d tab=%h vec_err=%0d need 65/f000/0", lat, tab, verr);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      mode_v[1] = 2'd1;
      @(negedge clk);
      start_v[1] = 1'b1;
      n = 0;
      while (done_w[1] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (n !== 33 || tab_w[1] !== 16'hFFFF) begin
         n_fail++; $display("FAIL b2b_first: got lat=%0d tab=%h need 33/ffff", n, tab_w[1]);
      end
      @(negedge clk);
      n_tests++;
      if (busy_w[1] !== 1'b1 || done_w[1] !== 1'b0 || tab_w[1] !== 16'h0000 || uns_w[1] !== 5'd0) begin
         n_fail++;
         $display("FAIL b2b_restart: got busy=%b done=%b tab=%h uns=%0d need 1/0/0000/0",
                  busy_w[1], done_w[1], tab_w[1], uns_w[1]);
      end
      n = 1;
      while (done_w[1] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      start_v[1] = 1'b0;
      n_tests++;
      if (n !== 33 || tab_w[1] !== 16'hFFFF || uns_w[1] !== exp_uns(16)) begin
         n_fail++;
         $display("FAIL b2b_second: got lat=%0d tab=%h uns=%0d need 33/ffff/%0d", n, tab_w[1], uns_w[1], exp_uns(16));
      end
      repeat (5) @(negedge clk);
      n_tests++;
      if (tab_w[1] !== 16'hFFFF || busy_w[1] !== 1'b0 || done_w[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_stable: got tab=%h busy=%b done=%b need ffff/0/0", tab_w[1], busy_w[1], done_w[1]);
      end
   endtask

   initial begin
      test_reset();
      test_and_sweep();
      test_tied();
      test_vectors();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
